demux32_4way_buffered: RTL
==========================

Name: demux32_4way_buffered

Overview:
- 1-to-4 buffered demultiplexer. The sequential counterpart of the team's N-way select muxes.
- Takes one valid/ready word stream and steers each word, by a per-word 2-bit select, into one of four independent per-channel FIFOs.
- Each channel drains on its own valid/ready handshake.
- Used to dispatch pipeline words (e.g. decoded uops, operand packets) from one producer to four consumer stages.

Parameters:
- WIDTH, 32, data width of every word.
- DEPTH, 2, entries per channel FIFO; power of 2, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  word will be accepted this cycle.
- in_data  input  WIDTH  word to steer.
- in_select  input  2  destination channel: 0=a, 1=b, 2=c, 3=d.
- out_valid  output  4  bit i = channel i FIFO non-empty.
- out_ready  input  4  bit i = channel i consumer takes head word.
- out_data_a  output  WIDTH  channel 0 head word.
- out_data_b  output  WIDTH  channel 1 head word.
- out_data_c  output  WIDTH  channel 2 head word.
- out_data_d  output  WIDTH  channel 3 head word.
- occupancy  output  4*(log2(DEPTH)+1)  per-channel entry count; channel i at slice [i*CW +: CW], CW = log2(DEPTH)+1.

Behaviour:
- Reset (reset=0, asynchronous):
  - All FIFOs empty; pointers and counts = 0; storage = 0.
  - out_valid=0, all out_data_*=0, occupancy=0, in_ready=1 (no channel full).
- Push:
  - Occurs on a clk edge when in_valid & in_ready.
  - in_data is written at the wr_ptr of channel in_select; that channel's wr_ptr increments mod DEPTH and its count increments.
- in_ready = ~full[in_select]. It is combinational from in_select and registered counts only, never from out_ready.
  - There is no same-cycle credit from a pop on a full channel: a full channel stays stalled for that cycle even if popped.
- Pop:
  - Channel i pops when out_valid[i] & out_ready[i]; its rd_ptr increments mod DEPTH and its count decrements.
  - out_ready[i] while empty has no effect.
- Head word:
  - out_data_x = storage[rd_ptr] of that channel. It is meaningful only while out_valid is high.
  - When the channel is empty it shows the stale slot content, not forced to 0.
- Latency: a word pushed at edge N shows out_valid at edge N (visible the cycle after acceptance). There is no combinational in-to-out path.
- Simultaneous push and pop on the same non-full, non-empty channel: count unchanged, both pointers advance.
- Simultaneous push to empty channel i and assertion of out_ready[i]: no pop, because out_valid[i] was 0 that cycle.
- Pops on all four channels and a push can all occur in one cycle. Channels are fully independent.
- Ordering: per-channel FIFO order is preserved. No ordering guarantee across channels.
- Wrap-around: pointers wrap from DEPTH-1 to 0. Full when count==DEPTH; empty when count==0.
- Reset mid-operation: all buffered words are discarded immediately. No pop or push completes in the reset cycle.
- in_select is sampled only when in_valid=1. in_data and in_select must be held stable while in_valid & ~in_ready (producer obligation). The block does not latch them.

Optional Feature:
- Macro: DEMUX_BCAST_EN.
- Defined:
  - Adds input in_bcast (1 bit).
  - When in_bcast=1, in_select is ignored and in_ready = no channel full.
  - On push, in_data is written to all four FIFOs in the same edge; all four counts increment, or hold where that channel is simultaneously popped.
  - With in_bcast=0, behaviour is identical to the base block.
- Undefined: port absent; base behaviour only.

Test Plan:
- Reset then idle -> out_valid=4'b0000, in_ready=1, occupancy=0, all out_data_*=32'h0.
- Push 32'hDEAD_0001 sel=2, out_ready=0 -> the next cycle out_valid=4'b0100, out_data_c=32'hDEAD_0001, channel 2 occupancy=1; other channels unchanged.
- Push 3 words to sel=1 (DEPTH=2) with out_ready=0 -> first two accepted; in_ready=0 on the third while sel=1; switching to sel=0 gives in_ready=1 the same cycle.
- Channel 1 full, assert out_ready[1]=1 and push to sel=1 in the same cycle -> push not accepted that cycle; pop occurs; next cycle in_ready=1 and the push completes; FIFO order 1,2,3 observed on out_data_b.
- Continuous push/pop on channel 3 for 10 words 32'h0..32'h9 with out_ready=1 -> all 10 emerge in order; pointers wrap cleanly; occupancy stays at 1 in steady state.
- Assert reset low with 2 words in channel 0 and 1 in channel 3 -> out_valid drops to 0 asynchronously before the next edge; after release, in_ready=1 and no stale word reappears.
- (DEMUX_BCAST_EN) in_bcast=1, push 32'hCAFE_F00D -> next cycle out_valid=4'b1111 and all out_data_*=32'hCAFE_F00D; with any channel full, in_ready=0.

Source files
------------

// File: rtl/demux32_4way_buffered.sv
// 1-to-4 buffered demultiplexer: steers a valid/ready word stream into four per-channel FIFOs.
// Optional macro DEMUX_BCAST_EN adds in_bcast, which writes a word into all four FIFOs at once.
module demux32_4way_buffered #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WIDTH-1:0]                    in_data,
    input  logic [1:0]                          in_select,
`ifdef DEMUX_BCAST_EN
    input  logic                                in_bcast,
`endif
    output logic [3:0]                          out_valid,
    input  logic [3:0]                          out_ready,
    output logic [WIDTH-1:0]                    out_data_a,
    output logic [WIDTH-1:0]                    out_data_b,
    output logic [WIDTH-1:0]                    out_data_c,
    output logic [WIDTH-1:0]                    out_data_d,
    output logic [4*($clog2(DEPTH)+1)-1:0]      occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem    [4][DEPTH];
    logic [PW-1:0]    rd_ptr [4];
    logic [PW-1:0]    wr_ptr [4];
    logic [CW-1:0]    count  [4];
    logic [3:0]       full;
    logic [3:0]       push;
    logic [3:0]       pop;

    // in_ready depends only on registered counts, so a pop never frees a slot in the same cycle
    always_comb begin
        full      = '0;
        out_valid = '0;
        occupancy = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            full[i]                = (count[i] == CW'(DEPTH));
            out_valid[i]           = (count[i] != '0);
            occupancy[i*CW +: CW]  = count[i];
        end
        pop = out_valid & out_ready;
`ifdef DEMUX_BCAST_EN
        in_ready = in_bcast ? ~|full : ~full[in_select];
`else
        in_ready = ~full[in_select];
`endif
        push = '0;
        if (in_valid && in_ready) begin
`ifdef DEMUX_BCAST_EN
            if (in_bcast) push = '1;
            else          push[in_select] = 1'b1;
`else
            push[in_select] = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
                for (int unsigned j = 0; j < DEPTH; j++) mem[i][j] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= in_data;
                    wr_ptr[i]         <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) rd_ptr[i] <= rd_ptr[i] + PW'(1);
                if (push[i] && !pop[i])      count[i] <= count[i] + CW'(1);
                else if (!push[i] && pop[i]) count[i] <= count[i] - CW'(1);
            end
        end
    end

    // Head words show the slot at rd_ptr even when empty (stale content)
    assign out_data_a = mem[0][rd_ptr[0]];
    assign out_data_b = mem[1][rd_ptr[1]];
    assign out_data_c = mem[2][rd_ptr[2]];
    assign out_data_d = mem[3][rd_ptr[3]];
endmodule
